// File: rtl/vdp_layer_mux.sv
// VDP layer mux: fixed-priority VRAM read arbiter with latency-matched data tags,
// transparent layer compositor with sticky collision, and a timing-signal delay line.
module vdp_layer_mux #(
  parameter int unsigned NUM_LAYERS      = 2,
  parameter int unsigned VRAM_SIZE       = 8192,
  parameter int unsigned VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE),
  parameter int unsigned SYNC_WIDTH      = 8,
  parameter int unsigned PIPE_LEN        = 12,
  parameter int unsigned RD_LATENCY      = 1
) (
  input  logic                                  pxclk,
  input  logic                                  reset,
  input  logic [SYNC_WIDTH-1:0]                 sync_in,
  output logic [SYNC_WIDTH-1:0]                 sync_out,
  input  logic [NUM_LAYERS-1:0]                 layer_rd_req,
  input  logic [NUM_LAYERS*VRAM_ADDR_WIDTH-1:0] layer_addr,
  output logic [NUM_LAYERS-1:0]                 layer_rd_grant,
  output logic [NUM_LAYERS-1:0]                 layer_data_valid,
  output logic [VRAM_ADDR_WIDTH-1:0]            vdp_dma_addr,
  output logic                                  vdp_dma_rd_tick,
  input  logic [NUM_LAYERS*4-1:0]               layer_color,
  input  logic [NUM_LAYERS-1:0]                 layer_enable,
  input  logic [3:0]                            backdrop_color,
  input  logic                                  pixel_valid,
  input  logic                                  collision_clr,
  output logic                                  collision,
  output logic [3:0]                            color_out
);

  logic [NUM_LAYERS-1:0]      win_grant;
  logic [VRAM_ADDR_WIDTH-1:0] win_addr;
  logic                       win_any;

  logic [3:0]                 comp_color;
  logic                       seen_opaque;
  logic                       multi_opaque;

  logic [NUM_LAYERS-1:0]      tag_pipe  [RD_LATENCY];
  logic [SYNC_WIDTH-1:0]      sync_pipe [PIPE_LEN];

  // Lowest index wins: the first asserted request found in ascending order is kept.
  always_comb begin
    win_grant = '0;
    win_addr  = '0;
    win_any   = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (layer_rd_req[i] && !win_any) begin
        win_any      = 1'b1;
        win_grant[i] = 1'b1;
        win_addr     = layer_addr[i*VRAM_ADDR_WIDTH +: VRAM_ADDR_WIDTH];
      end
    end
  end

  // Highest index wins visually: later opaque layers overwrite earlier ones.
  always_comb begin
    comp_color   = backdrop_color;
    seen_opaque  = 1'b0;
    multi_opaque = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (layer_enable[i] && (layer_color[i*4 +: 4] != 4'h0)) begin
        comp_color = layer_color[i*4 +: 4];
        if (seen_opaque) multi_opaque = 1'b1;
        seen_opaque = 1'b1;
      end
    end
  end

  always_ff @(posedge pxclk) begin
    if (reset) begin
      layer_rd_grant  <= '0;
      vdp_dma_rd_tick <= 1'b0;
      vdp_dma_addr    <= '0;
    end else begin
      layer_rd_grant  <= win_grant;
      vdp_dma_rd_tick <= win_any;
      if (win_any) vdp_dma_addr <= win_addr;
    end
  end

  // Tags track the issued grant so data_valid lands RD_LATENCY cycles after rd_tick.
  always_ff @(posedge pxclk) begin
    if (reset) begin
      for (int unsigned k = 0; k < RD_LATENCY; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= layer_rd_grant;
      for (int unsigned k = 1; k < RD_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign layer_data_valid = tag_pipe[RD_LATENCY-1];

  always_ff @(posedge pxclk) begin
    if (reset) begin
      color_out <= '0;
      collision <= 1'b0;
    end else begin
      color_out <= comp_color;
      if (pixel_valid && multi_opaque) collision <= 1'b1;
      else if (collision_clr)          collision <= 1'b0;
    end
  end

  always_ff @(posedge pxclk) begin
    if (reset) begin
      for (int unsigned k = 0; k < PIPE_LEN; k++) sync_pipe[k] <= '0;
    end else begin
      sync_pipe[0] <= sync_in;
      for (int unsigned k = 1; k < PIPE_LEN; k++) sync_pipe[k] <= sync_pipe[k-1];
    end
  end

  assign sync_out = sync_pipe[PIPE_LEN-1];

endmodule

// File: tb/tb_vdp_layer_mux.sv
// Directed bench for vdp_layer_mux with three layers and a two-cycle VRAM read latency.
module tb_vdp_layer_mux;

  localparam int unsigned NL = 3;
  localparam int unsigned AW = 13;
  localparam int unsigned SW = 8;

  logic              pxclk;
  logic              reset;
  logic [SW-1:0]     sync_in;
  logic [SW-1:0]     sync_out;
  logic [NL-1:0]     layer_rd_req;
  logic [NL*AW-1:0]  layer_addr;
  logic [NL-1:0]     layer_rd_grant;
  logic [NL-1:0]     layer_data_valid;
  logic [AW-1:0]     vdp_dma_addr;
  logic              vdp_dma_rd_tick;
  logic [NL*4-1:0]   layer_color;
  logic [NL-1:0]     layer_enable;
  logic [3:0]        backdrop_color;
  logic              pixel_valid;
  logic              collision_clr;
  logic              collision;
  logic [3:0]        color_out;

  int vectors;
  int miscompares;

  vdp_layer_mux #(
    .NUM_LAYERS (NL),
    .VRAM_SIZE  (8192),
    .SYNC_WIDTH (SW),
    .PIPE_LEN   (12),
    .RD_LATENCY (2)
  ) dut (
    .pxclk            (pxclk),
    .reset            (reset),
    .sync_in          (sync_in),
    .sync_out         (sync_out),
    .layer_rd_req     (layer_rd_req),
    .layer_addr       (layer_addr),
    .layer_rd_grant   (layer_rd_grant),
    .layer_data_valid (layer_data_valid),
    .vdp_dma_addr     (vdp_dma_addr),
    .vdp_dma_rd_tick  (vdp_dma_rd_tick),
    .layer_color      (layer_color),
    .layer_enable     (layer_enable),
    .backdrop_color   (backdrop_color),
    .pixel_valid      (pixel_valid),
    .collision_clr    (collision_clr),
    .collision        (collision),
    .color_out        (color_out)
  );

  initial pxclk = 1'b0;
  always #5 pxclk = ~pxclk;

  task automatic step();
    @(posedge pxclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset with every input driven nonzero
    reset          = 1'b1;
    sync_in        = 8'hA5;
    layer_rd_req   = 3'b111;
    layer_addr     = {13'h0333, 13'h0222, 13'h0111};
    layer_color    = {4'h7, 4'h6, 4'h5};
    layer_enable   = 3'b111;
    backdrop_color = 4'hF;
    pixel_valid    = 1'b1;
    collision_clr  = 1'b1;
    repeat (3) step();
    chk("rst_sync_out",   sync_out,         0);
    chk("rst_grant",      layer_rd_grant,   0);
    chk("rst_data_valid", layer_data_valid, 0);
    chk("rst_dma_addr",   vdp_dma_addr,     0);
    chk("rst_rd_tick",    vdp_dma_rd_tick,  0);
    chk("rst_collision",  collision,        0);
    chk("rst_color_out",  color_out,        0);

    // Delay line: zeros for the flush period, then sync_in from 12 cycles back
    reset         = 1'b0;
    layer_rd_req  = 3'b000;
    layer_enable  = 3'b000;
    pixel_valid   = 1'b0;
    collision_clr = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      sync_in = 8'(8'h10 + n);
      step();
      chk("sync_delay", sync_out, (n >= 12) ? 8'(8'h10 + n - 11) : 8'h00);
    end
    chk("idle_tick", vdp_dma_rd_tick, 0);
    chk("idle_addr", vdp_dma_addr,    0);

    // Priority: layers 1 and 2 requesting, layer 1 wins
    layer_addr   = {13'h0200, 13'h0100, 13'h0ABC};
    layer_rd_req = 3'b110;
    step();
    chk("prio_grant", layer_rd_grant,   3'b010);
    chk("prio_addr",  vdp_dma_addr,     13'h0100);
    chk("prio_tick",  vdp_dma_rd_tick,  1);
    chk("prio_dv0",   layer_data_valid, 0);
    layer_rd_req = 3'b100;
    step();
    chk("prio2_grant", layer_rd_grant,   3'b100);
    chk("prio2_addr",  vdp_dma_addr,     13'h0200);
    chk("tag_dv_t1",   layer_data_valid, 0);
    layer_rd_req = 3'b000;
    step();
    chk("tag_dv_t2",   layer_data_valid, 3'b010);
    chk("idle2_tick",  vdp_dma_rd_tick,  0);
    chk("idle2_grant", layer_rd_grant,   0);
    chk("idle2_addr",  vdp_dma_addr,     13'h0200);
    step();
    chk("tag_dv_l2",   layer_data_valid, 3'b100);
    chk("idle3_addr",  vdp_dma_addr,     13'h0200);
    step();
    chk("tag_dv_done", layer_data_valid, 0);

    // All requesting: layer 0 wins back-to-back
    layer_rd_req = 3'b111;
    step();
    chk("all_grant", layer_rd_grant, 3'b001);
    chk("all_addr",  vdp_dma_addr,   13'h0ABC);
    step();
    chk("all_grant2", layer_rd_grant, 3'b001);
    layer_rd_req = 3'b000;
    step();
    chk("all_idle", layer_rd_grant, 0);

    // Compositing with pixel_valid low (collision must not set)
    backdrop_color = 4'h4;
    layer_color    = {4'h9, 4'h0, 4'h5};
    layer_enable   = 3'b111;
    step();
    chk("comp_all", color_out, 4'h9);
    chk("comp_nocoll", collision, 0);
    layer_enable = 3'b011;
    step();
    chk("comp_en011", color_out, 4'h5);
    layer_enable = 3'b010;
    step();
    chk("comp_l1_transparent", color_out, 4'h4);
    layer_enable = 3'b111;
    layer_color  = 12'h000;
    step();
    chk("comp_backdrop", color_out, 4'h4);

    // Collision
    layer_color = {4'h0, 4'h3, 4'h5};
    layer_enable = 3'b001;
    pixel_valid  = 1'b1;
    step();
    chk("coll_disabled", collision, 0);
    layer_color  = {4'h0, 4'h0, 4'h5};
    layer_enable = 3'b111;
    step();
    chk("coll_single", collision, 0);
    layer_color = {4'h0, 4'h3, 4'h5};
    step();
    chk("coll_set",   collision, 1);
    chk("coll_color", color_out, 4'h3);
    pixel_valid = 1'b0;
    step();
    chk("coll_sticky", collision, 1);
    pixel_valid   = 1'b1;
    collision_clr = 1'b1;
    step();
    chk("coll_set_wins", collision, 1);
    pixel_valid = 1'b0;
    step();
    chk("coll_clear", collision, 0);
    collision_clr = 1'b0;

    // Reset the cycle after a grant discards the in-flight tag
    layer_rd_req = 3'b010;
    step();
    chk("mid_grant", layer_rd_grant, 3'b010);
    layer_rd_req = 3'b000;
    reset        = 1'b1;
    step();
    chk("mid_rst_dv", layer_data_valid, 0);
    reset = 1'b0;
    step();
    chk("mid_dv1", layer_data_valid, 0);
    step();
    chk("mid_dv2", layer_data_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
